// File: rtl/vga_fb_pkg.sv
// Shared types, framebuffer geometry and the pixel-to-address helper for the
// VGA framebuffer arbiter and its clear engine.
package vga_fb_pkg;

    localparam int unsigned FB_W    = 160;
    localparam int unsigned FB_H    = 120;
    localparam int unsigned SHIFT   = 2;
    localparam int unsigned COLOR_W = 8;
    localparam int unsigned ADDR_W  = 15;
    localparam int unsigned HACTIVE = 640;
    localparam int unsigned VACTIVE = 480;
    localparam int unsigned HTOTAL  = 800;
    localparam int unsigned VTOTAL  = 525;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [ADDR_W-1:0]  fb_addr_t;

    localparam color_t CLEAR_COLOR = 8'h00;

    typedef enum logic {
        CLR_IDLE,
        CLR_RUN
    } clear_state_t;

    // Display coordinate (x,y) to linear framebuffer address, computed at ADDR_W bits
    function automatic fb_addr_t fb_addr(input logic [9:0] x, input logic [9:0] y);
        fb_addr_t row;
        fb_addr_t col;
        row = fb_addr_t'(y >> SHIFT);
        col = fb_addr_t'(x >> SHIFT);
        return fb_addr_t'(row * fb_addr_t'(FB_W)) + col;
    endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Full-buffer clear engine: walks addresses 0..FB_W*FB_H-1, one per granted
// write slot. Only compiled when FB_CLEAR_EN is defined, matching the single
// place the arbiter instantiates it.
`ifdef FB_CLEAR_EN
module fb_clear_engine
    import vga_fb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              grant_i,
    output logic              req_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);

    clear_state_t      state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    // Clear FSM: start from IDLE only, advance the counter on each grant, leave after the last address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                CLR_IDLE: begin
                    if (start_i) begin
                        state_q <= CLR_RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLR_RUN: begin
                    if (grant_i) begin
                        if (cnt_q == LAST_ADDR) begin
                            state_q <= CLR_IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign req_o  = busy_q;
    assign addr_o = cnt_q;
    assign busy_o = busy_q;

endmodule
`endif

// File: rtl/vga_fb_arbiter.sv
// Time-slot scheduler for the single-port framebuffer RAM: display reads own
// the pix_en slot of active pixels, every other cycle is a write slot shared
// by the clear engine (highest priority) and writers A/B in round-robin.
// Optional clear engine enabled with `define FB_CLEAR_EN.
module vga_fb_arbiter
    import vga_fb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_en,
    input  logic [9:0]         hcnt,
    input  logic [9:0]         vcnt,
    output logic [COLOR_W-1:0] pix_color,
    input  logic               wa_valid,
    output logic               wa_ready,
    input  logic [ADDR_W-1:0]  wa_addr,
    input  logic [COLOR_W-1:0] wa_data,
    input  logic               wb_valid,
    output logic               wb_ready,
    input  logic [ADDR_W-1:0]  wb_addr,
    input  logic [COLOR_W-1:0] wb_data,
    input  logic               clear_start,
    output logic               clear_busy,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_we,
    output logic [COLOR_W-1:0] ram_wdata,
    input  logic [COLOR_W-1:0] ram_rdata
);

    localparam logic [9:0]        HACT    = 10'(HACTIVE);
    localparam logic [9:0]        VACT    = 10'(VACTIVE);
    localparam logic [9:0]        HLAST   = 10'(HTOTAL - 1);
    localparam logic [9:0]        VLAST   = 10'(VTOTAL - 1);
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_W * FB_H - 1);

    logic       run_q;
    logic       rr_q, rr_d;
    logic       rd_pend_q;
    color_t     pix_q, pix_d;
    logic [9:0] nx, ny;
    logic       disp_slot, wr_slot;
    logic       grant_a, grant_b;
    logic       clr_req, clr_grant;
    fb_addr_t   clr_addr;

    // Lookahead pixel; wraps at end of line/frame so pixel 0 is fetched during blanking
    always_comb begin
        nx = hcnt + 10'd1;
        ny = vcnt;
        if (hcnt == HLAST) begin
            nx = '0;
            ny = (vcnt == VLAST) ? '0 : vcnt + 10'd1;
        end
        // run_q keeps the bus idle while reset is (or has just been) asserted
        disp_slot = run_q && pix_en && (nx < HACT) && (ny < VACT);
        wr_slot   = run_q && !disp_slot;
    end

`ifdef FB_CLEAR_EN
    fb_clear_engine u_clear (
        .clk     (clk),
        .reset   (reset),
        .start_i (clear_start),
        .grant_i (clr_grant),
        .req_o   (clr_req),
        .addr_o  (clr_addr),
        .busy_o  (clear_busy)
    );
    assign clr_grant = wr_slot && clr_req;
`else
    logic unused_clear_start;
    assign unused_clear_start = clear_start;
    assign clear_busy = 1'b0;
    assign clr_req    = 1'b0;
    assign clr_grant  = 1'b0;
    assign clr_addr   = '0;
`endif

    // Writer arbitration: a lone requester wins, contention follows the round-robin pointer
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (wr_slot && !clr_req) begin
            if (wa_valid && wb_valid) begin
                grant_a = !rr_q;
                grant_b = rr_q;
            end else begin
                grant_a = wa_valid;
                grant_b = wb_valid;
            end
        end
        rr_d = rr_q;
        if (grant_a) begin
            rr_d = 1'b1;
        end else if (grant_b) begin
            rr_d = 1'b0;
        end
    end

    // RAM port mux; out-of-range writer addresses are accepted but not written
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (disp_slot) begin
            ram_addr = fb_addr(nx, ny);
        end else if (clr_grant) begin
            ram_addr  = clr_addr;
            ram_we    = 1'b1;
            ram_wdata = CLEAR_COLOR;
        end else if (grant_a) begin
            ram_addr  = wa_addr;
            ram_we    = (wa_addr <= FB_LAST);
            ram_wdata = wa_data;
        end else if (grant_b) begin
            ram_addr  = wb_addr;
            ram_we    = (wb_addr <= FB_LAST);
            ram_wdata = wb_data;
        end
    end

    // Capture read data one cycle after each display slot
    always_comb begin
        pix_d = rd_pend_q ? ram_rdata : pix_q;
    end

    // Arbiter state: run enable, round-robin pointer, read-pending flag, pixel register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q     <= 1'b0;
            rr_q      <= 1'b0;
            rd_pend_q <= 1'b0;
            pix_q     <= '0;
        end else begin
            run_q     <= 1'b1;
            rr_q      <= rr_d;
            rd_pend_q <= disp_slot;
            pix_q     <= pix_d;
        end
    end

    assign wa_ready  = grant_a;
    assign wb_ready  = grant_b;
    assign pix_color = ((hcnt >= HACT) || (vcnt >= VACT)) ? '0 : pix_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter with a behavioural
// 1-cycle-latency RAM and a software VGA counter model.
module tb_vga_fb_arbiter;
    import vga_fb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic [9:0]  hcnt, vcnt;
    logic [7:0]  pix_color;
    logic        wa_valid, wa_ready, wb_valid, wb_ready;
    logic [14:0] wa_addr, wb_addr;
    logic [7:0]  wa_data, wb_data;
    logic        clear_start, clear_busy;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:32767];
    int          errors = 0;
    int          checks = 0;
    bit          vga_run = 1'b0;

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .pix_color   (pix_color),
        .wa_valid    (wa_valid),
        .wa_ready    (wa_ready),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .ram_addr    (ram_addr),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        logic prev_pe;
        @(posedge clk);
        #1;
        if (vga_run) begin
            prev_pe = pix_en;
            if (prev_pe) begin
                if (hcnt == 10'd799) begin
                    hcnt = 10'd0;
                    vcnt = (vcnt == 10'd524) ? 10'd0 : vcnt + 10'd1;
                end else begin
                    hcnt = hcnt + 10'd1;
                end
            end
            pix_en = ~prev_pe;
        end
    endtask

    task automatic place(input logic [9:0] h, input logic [9:0] v);
        hcnt = h;
        vcnt = v;
        pix_en = 1'b1;
    endtask

    task automatic goto_pixel(input logic [9:0] h, input logic [9:0] v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (pix_en && hcnt == h && vcnt == v) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; vga_run = 1'b0;
        pix_en = 1'b1; hcnt = 10'd100; vcnt = 10'd10;
        wa_valid = 1'b1; wa_addr = 15'd3; wa_data = 8'h12;
        wb_valid = 1'b1; wb_addr = 15'd4; wb_data = 8'h34;
        clear_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
        checks++; if (ram_addr !== 15'd0) begin errors++; $display("FAIL reset_ram_addr: got %0d expected 0", ram_addr); end
        checks++; if (wa_ready !== 1'b0) begin errors++; $display("FAIL reset_wa_ready: got %b expected 0", wa_ready); end
        checks++; if (wb_ready !== 1'b0) begin errors++; $display("FAIL reset_wb_ready: got %b expected 0", wb_ready); end
        checks++; if (pix_color !== 8'h00) begin errors++; $display("FAIL reset_pix_color: got %h expected 00", pix_color); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL reset_clear_busy: got %b expected 0", clear_busy); end
        wa_valid = 1'b0; wb_valid = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_scanout();
        bit ok;
        vga_run = 1'b1;
        place(10'd6, 10'd4);
        for (int i = 0; i < 40; i++) begin
            #1;
            if (pix_en && hcnt == 10'd7) begin
                checks++; if (ram_addr !== 15'd162 || ram_we !== 1'b0) begin errors++; $display("FAIL disp_slot_addr: got addr %0d we %b expected 162 we 0", ram_addr, ram_we); end
            end
            if (pix_en && hcnt >= 10'd8 && hcnt <= 10'd16) begin
                checks++; if (pix_color !== 8'hA0 + 8'(hcnt >> 2)) begin errors++; $display("FAIL scan_pixel h=%0d: got %h expected %h", hcnt, pix_color, 8'hA0 + 8'(hcnt >> 2)); end
            end
            tick();
        end
        // last active pixel: no lookahead, slot goes to a writer
        wa_valid = 1'b1; wa_addr = 15'd30; wa_data = 8'h1E;
        place(10'd636, 10'd4);
        goto_pixel(10'd639, 10'd4, ok);
        checks++; if (!ok || wa_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 15'd30) begin errors++; $display("FAIL h639_write_slot: got ok %b ready %b we %b addr %0d expected 1 1 1 30", ok, wa_ready, ram_we, ram_addr); end
        wa_valid = 1'b0;
        place(10'd696, 10'd4);
        goto_pixel(10'd700, 10'd4, ok);
        checks++; if (!ok || pix_color !== 8'h00) begin errors++; $display("FAIL blank_h700: got ok %b pix %h expected 1 00", ok, pix_color); end
        place(10'd796, 10'd7);
        goto_pixel(10'd0, 10'd8, ok);
        checks++; if (!ok || pix_color !== 8'h40) begin errors++; $display("FAIL line_start_v8: got ok %b pix %h expected 1 40", ok, pix_color); end
        mem[0] = 8'h77;
        place(10'd796, 10'd524);
        goto_pixel(10'd0, 10'd0, ok);
        checks++; if (!ok || pix_color !== 8'h77) begin errors++; $display("FAIL frame_start_v0: got ok %b pix %h expected 1 77", ok, pix_color); end
        mem[0] = 8'h00;
    endtask

    task automatic test_write_active();
        vga_run = 1'b1;
        place(10'd100, 10'd10);
        wa_valid = 1'b1; wa_addr = 15'd5; wa_data = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (wa_ready !== !pix_en) begin errors++; $display("FAIL active_wa_ready c%0d: got %b expected %b", i, wa_ready, !pix_en); end
            checks++; if (ram_we !== !pix_en) begin errors++; $display("FAIL active_ram_we c%0d: got %b expected %b", i, ram_we, !pix_en); end
            tick();
        end
        wa_valid = 1'b0;
        tick();
        #1;
        checks++; if (mem[5] !== 8'h3C) begin errors++; $display("FAIL active_ram5: got %h expected 3C", mem[5]); end
    endtask

    task automatic test_round_robin();
        bit exp_a;
        tick();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        vga_run = 1'b1;
        hcnt = 10'd0; vcnt = 10'd490; pix_en = 1'b0;
        wa_valid = 1'b1; wa_addr = 15'd20; wa_data = 8'h11;
        wb_valid = 1'b1; wb_addr = 15'd21; wb_data = 8'h22;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_a = (i % 2 == 0);
            checks++; if (wa_ready !== exp_a || wb_ready !== !exp_a) begin errors++; $display("FAIL rr_grant c%0d: got a %b b %b expected a %b b %b", i, wa_ready, wb_ready, exp_a, !exp_a); end
            checks++; if (ram_addr !== (exp_a ? 15'd20 : 15'd21)) begin errors++; $display("FAIL rr_addr c%0d: got %0d expected %0d", i, ram_addr, exp_a ? 20 : 21); end
            tick();
        end
        wa_valid = 1'b0;
        #1;
        checks++; if (wb_ready !== 1'b1) begin errors++; $display("FAIL rr_lone_b: got %b expected 1", wb_ready); end
        tick();
        wb_valid = 1'b0;
        #1;
        checks++; if (mem[20] !== 8'h11 || mem[21] !== 8'h22) begin errors++; $display("FAIL rr_ram: got %h %h expected 11 22", mem[20], mem[21]); end
    endtask

    task automatic test_out_of_range();
        vga_run = 1'b1;
        hcnt = 10'd0; vcnt = 10'd490; pix_en = 1'b0;
        mem[19200] = 8'h5A;
        wa_valid = 1'b1; wa_addr = 15'd19200; wa_data = 8'hFF;
        #1;
        checks++; if (wa_ready !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL oor_drop: got ready %b we %b expected 1 0", wa_ready, ram_we); end
        tick();
        wa_addr = 15'd19199; wa_data = 8'hC3;
        #1;
        checks++; if (wa_ready !== 1'b1 || ram_we !== 1'b1) begin errors++; $display("FAIL last_addr_write: got ready %b we %b expected 1 1", wa_ready, ram_we); end
        tick();
        wa_valid = 1'b0;
        #1;
        checks++; if (mem[19200] !== 8'h5A || mem[19199] !== 8'hC3) begin errors++; $display("FAIL oor_ram: got %h %h expected 5A C3", mem[19200], mem[19199]); end
    endtask

`ifdef FB_CLEAR_EN
    task automatic test_clear();
        int  n_wr, bad, starve;
        bit  done;
        vga_run = 1'b0;
        hcnt = 10'd0; vcnt = 10'd490; pix_en = 1'b0;
        wa_valid = 1'b1; wa_addr = 15'd7; wa_data = 8'h99;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        #1;
        checks++; if (clear_busy !== 1'b1) begin errors++; $display("FAIL clear_busy_rise: got %b expected 1", clear_busy); end
        n_wr = 0; bad = 0; starve = 0; done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (!clear_busy) begin done = 1'b1; break; end
            if (wa_ready) starve++;
            if (ram_we) begin
                if (ram_addr !== 15'(n_wr) || ram_wdata !== 8'h00) bad++;
                n_wr++;
            end
            if (i == 5000) clear_start = 1'b1;
            tick();
            clear_start = 1'b0;
            #1;
        end
        checks++; if (!done || n_wr != 19200) begin errors++; $display("FAIL clear_count: got done %b writes %0d expected 1 19200", done, n_wr); end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_sequence: got %0d bad writes expected 0", bad); end
        checks++; if (starve != 0) begin errors++; $display("FAIL clear_starve: got %0d A grants expected 0", starve); end
        checks++; if (wa_ready !== 1'b1) begin errors++; $display("FAIL clear_after_a: got %b expected 1", wa_ready); end
        tick();
        wa_valid = 1'b0;
        #1;
        checks++; if (mem[100] !== 8'h00 || mem[19199] !== 8'h00) begin errors++; $display("FAIL clear_ram: got %h %h expected 00 00", mem[100], mem[19199]); end
    endtask

    task automatic test_reset_mid_clear();
        int n_wr, extra;
        vga_run = 1'b0;
        hcnt = 10'd0; vcnt = 10'd490; pix_en = 1'b0;
        wa_valid = 1'b1; wa_addr = 15'd9; wa_data = 8'h55;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        #1;
        n_wr = 0;
        for (int i = 0; i < 2000; i++) begin
            if (n_wr == 1000) break;
            if (ram_we) n_wr++;
            tick();
            #1;
        end
        checks++; if (n_wr != 1000) begin errors++; $display("FAIL midclear_reach: got %0d writes expected 1000", n_wr); end
        reset = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0 || clear_busy !== 1'b0 || wa_ready !== 1'b0 || ram_addr !== 15'd0) begin errors++; $display("FAIL midclear_reset: got we %b busy %b ready %b addr %0d expected 0 0 0 0", ram_we, clear_busy, wa_ready, ram_addr); end
        tick();
        reset = 1'b1;
        wa_valid = 1'b0;
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            #1;
            if (ram_we || clear_busy) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL midclear_after: got %0d active cycles expected 0", extra); end
    endtask
`else
    task automatic test_clear_disabled();
        vga_run = 1'b1;
        hcnt = 10'd0; vcnt = 10'd490; pix_en = 1'b0;
        wa_valid = 1'b1; wa_addr = 15'd40; wa_data = 8'h28;
        clear_start = 1'b1;
        #1;
        checks++; if (wa_ready !== 1'b1) begin errors++; $display("FAIL noclr_grant0: got %b expected 1", wa_ready); end
        tick();
        clear_start = 1'b0;
        #1;
        checks++; if (clear_busy !== 1'b0 || wa_ready !== 1'b1) begin errors++; $display("FAIL noclr_busy: got busy %b ready %b expected 0 1", clear_busy, wa_ready); end
        tick();
        wa_valid = 1'b0;
        #1;
        checks++; if (mem[40] !== 8'h28) begin errors++; $display("FAIL noclr_ram: got %h expected 28", mem[40]); end
    endtask
`endif

    initial begin
        for (int k = 0; k < 32768; k++) mem[k] = 8'(k);
        test_reset();
        test_scanout();
        test_write_active();
        test_round_robin();
        test_out_of_range();
`ifdef FB_CLEAR_EN
        test_clear();
        test_reset_mid_clear();
`else
        test_clear_disabled();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
